// File: rtl/mac_row_dual_pkg.sv
// Shared instruction-bit indices, dataflow mode encodings and the saturating adder.
// sat_add is only referenced when MAC_ROW_SATURATE_EN is defined.
package mac_pkg;

  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_DRAIN = 2;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Operands arrive sign-extended to 64 bits; the result is clamped to a signed `width`-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mac_row_dual_tile.sv
// One dual-dataflow MAC tile: 1-cycle registered forwarding east, registered south result.
// Define MAC_ROW_SATURATE_EN to saturate the psum/accumulator add instead of wrapping.
module mac_tile_dual
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_mode,
  input  logic [bw-1:0]      i_in_w,
  input  logic [2:0]         i_inst_w,
  input  logic [psum_bw-1:0] i_in_n,
  output logic [bw-1:0]      o_out_e,
  output logic [2:0]         o_inst_e,
  output logic [psum_bw-1:0] o_out_s,
  output logic               o_valid
);

  localparam int MW = (psum_bw > 2 * bw + 1) ? psum_bw : 2 * bw + 1;

  logic [bw-1:0]             r_a;
  logic [bw-1:0]             r_w;
  logic [2:0]                r_inst;
  logic                      r_load_ready;
  logic signed [psum_bw-1:0] r_acc;
  logic signed [psum_bw-1:0] r_out_s;
  logic                      r_valid;

  logic                      w_exec;
  logic                      w_drain;
  logic                      w_do_load;
  logic                      w_ld_fwd;
  logic [bw-1:0]             w_wt;
  logic signed [MW-1:0]      w_a_x;
  logic signed [MW-1:0]      w_wt_x;
  logic signed [MW-1:0]      w_prod_x;
  logic signed [psum_bw-1:0] w_prod;
  logic signed [psum_bw-1:0] w_addend;
  logic signed [psum_bw-1:0] w_sum;

  assign w_exec  = i_inst_w[INST_EXEC];
  assign w_drain = i_inst_w[INST_DRAIN];

  // WS: stationary weight; OS: weight streams in from the north on the low bits.
  assign w_wt     = (i_mode == MODE_OS) ? i_in_n[bw-1:0] : r_w;
  assign w_a_x    = MW'({1'b0, i_in_w});
  assign w_wt_x   = MW'($signed(w_wt));
  assign w_prod_x = w_a_x * w_wt_x;
  assign w_prod   = w_prod_x[psum_bw-1:0];

  assign w_addend = (i_mode == MODE_OS) ? r_acc : $signed(i_in_n);
`ifdef MAC_ROW_SATURATE_EN
  assign w_sum = psum_bw'(sat_add(64'(w_addend), 64'(w_prod), psum_bw));
`else
  assign w_sum = w_addend + w_prod;
`endif

  // A load is consumed by the first tile still waiting for a weight and only passed on once full.
  assign w_do_load = (i_mode == MODE_WS) && i_inst_w[INST_LOAD] && r_load_ready;
  assign w_ld_fwd  = i_inst_w[INST_LOAD] && ((i_mode == MODE_OS) || !r_load_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a          <= '0;
      r_w          <= '0;
      r_inst       <= '0;
      r_load_ready <= 1'b1;
      r_acc        <= '0;
      r_out_s      <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_a     <= i_in_w;
      r_inst  <= {w_drain, w_exec, w_ld_fwd};
      r_valid <= 1'b0;
      if (w_do_load) begin
        r_w          <= i_in_w;
        r_load_ready <= 1'b0;
      end
      if (i_mode == MODE_WS) begin
        if (w_exec) begin
          r_out_s <= w_sum;
          r_valid <= 1'b1;
        end
      end else if (w_drain) begin
        // The concurrent product restarts the accumulator so no sample is dropped.
        r_out_s <= r_acc;
        r_acc   <= w_exec ? w_prod : '0;
        r_valid <= 1'b1;
      end else if (w_exec) begin
        r_acc   <= w_sum;
        r_out_s <= psum_bw'(w_wt);
      end
    end
  end

  assign o_out_e  = r_a;
  assign o_inst_e = r_inst;
  assign o_out_s  = r_out_s;
  assign o_valid  = r_valid;

endmodule

// File: rtl/mac_row_dual.sv
// Systolic row of col dual-dataflow tiles (WS / OS) plus the shared, idle-gated mode register.
// MAC_ROW_SATURATE_EN selects saturating instead of wrapping psum/accumulator arithmetic.
module mac_row_dual
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [bw-1:0]          in_w,
  input  logic [2:0]             inst_w,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid
);

  logic                r_mode;
  logic [col:0][bw-1:0] w_a_chain;
  logic [col:0][2:0]    w_inst_chain;
  logic                w_busy;
  logic                w_a_unused;

  assign w_a_chain[0]    = in_w;
  assign w_inst_chain[0] = inst_w;
  assign w_a_unused      = ^w_a_chain[col];

  // Row input included so tile 0 never sees the mode flip on the same edge as its instruction.
  assign w_busy = |w_inst_chain;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode <= MODE_WS;
    end else if (!w_busy) begin
      r_mode <= mode;
    end
  end

  for (genvar j = 0; j < col; j++) begin : g_tile
    mac_tile_dual #(
      .bw     (bw),
      .psum_bw(psum_bw)
    ) u_tile (
      .clk     (clk),
      .reset   (reset),
      .i_mode  (r_mode),
      .i_in_w  (w_a_chain[j]),
      .i_inst_w(w_inst_chain[j]),
      .i_in_n  (in_n[j*psum_bw +: psum_bw]),
      .o_out_e (w_a_chain[j+1]),
      .o_inst_e(w_inst_chain[j+1]),
      .o_out_s (out_s[j*psum_bw +: psum_bw]),
      .o_valid (valid[j])
    );
  end

endmodule

// File: tb/tb_mac_row_dual.sv
// Bench for mac_row_dual (bw=4, psum_bw=8, col=8): history-based row model plus literal checks.
// Honours MAC_ROW_SATURATE_EN in the same way as the design.
module tb_mac_row_dual;

  localparam int BW   = 4;
  localparam int PW   = 8;
  localparam int COL  = 8;
  localparam int MAXT = 2048;

  logic              clk    = 1'b0;
  logic              reset  = 1'b0;
  logic              mode   = 1'b0;
  logic [BW-1:0]     in_w   = '0;
  logic [2:0]        inst_w = '0;
  logic [PW*COL-1:0] in_n   = '0;
  logic [PW*COL-1:0] out_s;
  logic [COL-1:0]    valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_row_dual #(.bw(BW), .psum_bw(PW), .col(COL)) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .in_w  (in_w),
    .inst_w(inst_w),
    .in_n  (in_n),
    .out_s (out_s),
    .valid (valid)
  );

  function automatic int fixw(input int x);
    int m;
`ifdef MAC_ROW_SATURATE_EN
    if (x > (1 << (PW - 1)) - 1) return (1 << (PW - 1)) - 1;
    if (x < -(1 << (PW - 1))) return -(1 << (PW - 1));
    return x;
`else
    m = x & ((1 << PW) - 1);
    if (m >= (1 << (PW - 1))) m = m - (1 << PW);
    return m;
`endif
  endfunction

  function automatic int sx4(input int v);
    int m;
    m = v & 15;
    if (m >= 8) m = m - 16;
    return m;
  endfunction

  function automatic int dut_out(input int j);
    logic [PW-1:0] s;
    s = out_s[j*PW +: PW];
    return int'($signed(s));
  endfunction

  function automatic int north(input int j);
    logic [PW-1:0] s;
    s = in_n[j*PW +: PW];
    return int'($signed(s));
  endfunction

  // Model: each tile j acts at edge t on the row input applied at edge t-j.
  int         t = 0;
  int         rst_t = 0;
  int         hw[MAXT];
  logic [2:0] hinst[MAXT];
  int         hld[MAXT];
  int         m_w[COL];
  int         m_acc[COL];
  int         m_out[COL];
  logic       m_vld[COL];
  logic       m_mode = 1'b0;
  int         load_cnt = 0;
  bit         m_ready = 0;

  always @(posedge clk) begin
    int d, a, nj, wt, prod, ld;
    logic [2:0] ins;
    bit busy;
    if (t >= MAXT) begin
      $display("FAIL model_history: got %0d cycles, limit %0d", t, MAXT);
      $fatal(1);
    end
    if (!reset) begin
      for (int j = 0; j < COL; j++) begin
        m_w[j] = 0; m_acc[j] = 0; m_out[j] = 0; m_vld[j] = 1'b0;
      end
      m_mode   = 1'b0;
      load_cnt = 0;
      rst_t    = t + 1;
      m_ready  = 1;
    end else begin
      hw[t]    = int'(in_w);
      hinst[t] = inst_w;
      hld[t]   = -1;
      if (inst_w[0] && m_mode == 1'b0 && load_cnt < COL) begin
        hld[t]   = load_cnt;
        load_cnt = load_cnt + 1;
      end
      for (int j = 0; j < COL; j++) begin
        d = t - j; a = 0; ins = 3'b000; ld = -1;
        if (d >= rst_t) begin
          a = hw[d]; ins = hinst[d]; ld = hld[d];
        end
        nj = north(j);
        m_vld[j] = 1'b0;
        if (m_mode == 1'b0) begin
          if (ins[1]) begin
            m_out[j] = fixw(nj + a * m_w[j]);
            m_vld[j] = 1'b1;
          end
          if (ld == j) m_w[j] = sx4(a);
        end else begin
          wt   = sx4(nj);
          prod = a * wt;
          if (ins[2]) begin
            m_out[j] = m_acc[j];
            m_acc[j] = ins[1] ? prod : 0;
            m_vld[j] = 1'b1;
          end else if (ins[1]) begin
            m_acc[j] = fixw(m_acc[j] + prod);
            m_out[j] = nj & 15;
          end
        end
      end
      busy = 0;
      for (int k = t - COL; k <= t; k++)
        if (k >= rst_t && hinst[k] != 3'b000) busy = 1;
      if (!busy) m_mode = mode;
    end
    t = t + 1;
  end

  always @(negedge clk) begin
    if (m_ready) begin
      for (int j = 0; j < COL; j++) begin
        n_vec = n_vec + 1;
        if (dut_out(j) != m_out[j]) begin
          n_err = n_err + 1;
          $display("FAIL model_out_s col%0d t=%0d: got %0d expected %0d", j, t, dut_out(j), m_out[j]);
        end
        n_vec = n_vec + 1;
        if (valid[j] !== m_vld[j]) begin
          n_err = n_err + 1;
          $display("FAIL model_valid col%0d t=%0d: got %0b expected %0b", j, t, valid[j], m_vld[j]);
        end
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int a, input logic [2:0] ins);
    @(posedge clk);
    #1;
    in_w   = a[BW-1:0];
    inst_w = ins;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 3'b000);
  endtask

  task automatic set_n(input int j, input int v);
    in_n[j*PW +: PW] = v[PW-1:0];
  endtask

  task automatic set_all(input int v);
    for (int j = 0; j < COL; j++) set_n(j, v);
  endtask

  // Tile 7 holds 8, which a signed 4-bit weight reads as -8.
  int ws_exp[COL] = '{13, 16, 19, 22, 25, 28, 31, -14};
  int ovf_exp;

  initial begin
`ifdef MAC_ROW_SATURATE_EN
    ovf_exp = 127;
`else
    ovf_exp = -128;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit("reset_valid", int'(valid), 0);
    lit("reset_out_s0", dut_out(0), 0);
    lit("reset_out_s7", dut_out(7), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int k = 1; k <= 9; k++) tick(k, 3'b001);
    idle(12);

    set_all(10);
    tick(3, 3'b010);
    tick(0, 3'b000);
    for (int c = 0; c < COL; c++) begin
      @(negedge clk);
      lit($sformatf("ws_valid_step%0d", c), int'(valid), 1 << c);
      lit($sformatf("ws_out_s%0d", c), dut_out(c), ws_exp[c]);
    end
    idle(4);

    set_all(127);
    tick(1, 3'b010);
    tick(0, 3'b000);
    @(negedge clk);
    lit("overflow_out_s0", dut_out(0), ovf_exp);
    idle(10);

    set_all(0);
    tick(1, 3'b010);
    tick(0, 3'b000);
    mode = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    lit("modeswitch_valid", int'(valid), 1 << 3);
    lit("modeswitch_out_s3", dut_out(3), 4);
    idle(12);

    set_n(0, -1);
    for (int j = 1; j < COL; j++) set_n(j, j);
    repeat (4) tick(2, 3'b010);
    idle(10);
    tick(0, 3'b100);
    tick(0, 3'b000);
    @(negedge clk);
    lit("os_drain_valid0", int'(valid[0]), 1);
    lit("os_drain_out_s0", dut_out(0), -8);
    @(negedge clk);
    lit("os_drain_pulse0", int'(valid[0]), 0);
    idle(10);
    lit("os_drain_out_s7", dut_out(7), 56);
    tick(0, 3'b100);
    tick(0, 3'b000);
    @(negedge clk);
    lit("os_redrain_out_s0", dut_out(0), 0);
    lit("os_redrain_valid0", int'(valid[0]), 1);
    idle(10);

    tick(2, 3'b010);
    tick(2, 3'b010);
    tick(2, 3'b110);
    tick(0, 3'b100);
    tick(0, 3'b000);
    @(negedge clk);
    lit("os_exec_drain_out_s0", dut_out(0), -2);
    mode = 1'b0;
    idle(14);

    tick(0, 3'b000);
    reset = 1'b0;
    tick(0, 3'b000);
    reset = 1'b1;
    tick(5, 3'b001);
    tick(6, 3'b001);
    tick(7, 3'b001);
    tick(0, 3'b000);
    reset = 1'b0;
    tick(0, 3'b000);
    reset = 1'b1;
    idle(3);
    set_all(20);
    tick(1, 3'b010);
    idle(12);
    lit("midreset_out_s0", dut_out(0), 20);
    lit("midreset_out_s2", dut_out(2), 20);

    tick(3, 3'b001);
    idle(4);
    tick(1, 3'b010);
    idle(12);
    lit("reload_out_s0", dut_out(0), 23);
    lit("reload_out_s1", dut_out(1), 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
